// File: rtl/dvp_pattern_tx_if.sv
// rtl/dvp_pattern_tx_if.sv - DVP pixel bus (vsync, href, byte data) between pattern source and capture
interface dvp_pattern_tx_if;
    logic       O_vsync;
    logic       O_href;
    logic [7:0] O_data;

    modport master (output O_vsync, output O_href, output O_data);
    modport slave  (input  O_vsync, input  O_href, input  O_data);
endinterface

// File: rtl/dvp_pattern_tx.sv
// rtl/dvp_pattern_tx.sv - synthetic OV5640-style DVP source emitting RGB565 test patterns, two bytes per pixel
module dvp_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 288,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 16,
    parameter int V_FRONT     = 8
) (
    input  logic                I_pxl_clk,
    input  logic                I_rst_n,
    input  logic                I_en,
    input  logic [1:0]          I_pattern_sel,
    input  logic [15:0]         I_solid_rgb,
    dvp_pattern_tx_if.master    o_dvp,
    output logic                O_busy,
    output logic [15:0]         O_frame_cnt
);

    localparam int LINE_T    = 2 * H_ACTIVE + H_BLANK;
    localparam int BAR_BYTES = H_ACTIVE / 4;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_col, r_ln, w_ln_last;
    logic [15:0] r_bar_cnt;
    logic [2:0]  r_bar_idx;
    logic [1:0]  r_sel;
    logic [15:0] r_solid;
    logic        r_vsync, r_href, r_busy;
    logic [7:0]  r_data;
    logic [15:0] r_frame_cnt;
    logic        w_line_end, w_phase_end, w_latch, w_href_nxt;
    logic [15:0] w_pixel;
    logic [7:0]  w_byte;

    always_comb begin
        w_ln_last = 16'd0;
        case (r_state)
            S_VSYNC:  w_ln_last = 16'(VSYNC_LINES - 1);
            S_VBACK:  w_ln_last = 16'(V_BACK - 1);
            S_ACTIVE: w_ln_last = 16'(V_ACTIVE - 1);
            S_VFRONT: w_ln_last = 16'(V_FRONT - 1);
            default:  w_ln_last = 16'd0;
        endcase
    end

    assign w_line_end  = (r_col == 16'(LINE_T - 1));
    assign w_phase_end = w_line_end && (r_ln == w_ln_last);
    // Pattern inputs are captured only when a frame starts, so a frame is always uniform.
    assign w_latch     = I_en && ((r_state == S_IDLE) || ((r_state == S_VFRONT) && w_phase_end));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (I_en)        w_state_nxt = S_VSYNC;
            S_VSYNC:  if (w_phase_end) w_state_nxt = S_VBACK;
            S_VBACK:  if (w_phase_end) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_phase_end) w_state_nxt = S_VFRONT;
            S_VFRONT: if (w_phase_end) w_state_nxt = I_en ? S_VSYNC : S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Bar counter advances one byte per clock so bar boundaries need no divider.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_col     <= 16'd0;
            r_ln      <= 16'd0;
            r_bar_cnt <= 16'd0;
            r_bar_idx <= 3'd0;
        end else begin
            if (r_state == S_IDLE || w_line_end) begin
                r_col     <= 16'd0;
                r_bar_cnt <= 16'd0;
                r_bar_idx <= 3'd0;
            end else begin
                r_col <= r_col + 16'd1;
                if (r_bar_cnt == 16'(BAR_BYTES - 1)) begin
                    r_bar_cnt <= 16'd0;
                    r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + 16'd1;
                end
            end
            if (r_state == S_IDLE || w_phase_end) r_ln <= 16'd0;
            else if (w_line_end)                  r_ln <= r_ln + 16'd1;
        end
    end

    always_comb begin
        w_pixel = 16'h0000;
        case (r_sel)
            2'd0: begin
                case (r_bar_idx)
                    3'd0:    w_pixel = 16'hFFFF;
                    3'd1:    w_pixel = 16'hFFE0;
                    3'd2:    w_pixel = 16'h07FF;
                    3'd3:    w_pixel = 16'h07E0;
                    3'd4:    w_pixel = 16'hF81F;
                    3'd5:    w_pixel = 16'hF800;
                    3'd6:    w_pixel = 16'h001F;
                    default: w_pixel = 16'h0000;
                endcase
            end
            // Pixel column x is r_col >> 1, so x[7:3] = r_col[8:4] and x[4] = r_col[5].
            2'd1:    w_pixel = {r_col[8:4], r_col[8:3], r_col[8:4]};
            2'd2:    w_pixel = (r_col[5] ^ r_ln[4]) ? 16'hFFFF : 16'h0000;
            default: w_pixel = r_solid;
        endcase
    end

    assign w_href_nxt = (r_state == S_ACTIVE) && (r_col < 16'(2 * H_ACTIVE));
    assign w_byte     = r_col[0] ? w_pixel[7:0] : w_pixel[15:8];

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_data      <= 8'h00;
            r_busy      <= 1'b0;
            r_frame_cnt <= 16'h0000;
            r_sel       <= 2'd0;
            r_solid     <= 16'h0000;
        end else begin
            r_vsync <= (r_state == S_VSYNC);
            r_href  <= w_href_nxt;
            r_data  <= w_href_nxt ? w_byte : 8'h00;
            r_busy  <= (r_state != S_IDLE);
            if ((r_state == S_VFRONT) && w_phase_end) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_latch) begin
                r_sel   <= I_pattern_sel;
                r_solid <= I_solid_rgb;
            end
        end
    end

    assign o_dvp.O_vsync = r_vsync;
    assign o_dvp.O_href  = r_href;
    assign o_dvp.O_data  = r_data;
    assign O_busy        = r_busy;
    assign O_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb/tb_dvp_pattern_tx.sv - directed bench for dvp_pattern_tx on a 140-clock miniature frame
module tb_dvp_pattern_tx;

    localparam int H_ACTIVE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] solid = 16'h0000;
    logic        busy;
    logic [15:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic        cap_v [0:140];
    logic        cap_h [0:140];
    logic        cap_b [0:140];
    logic [7:0]  cap_d [0:140];
    logic [15:0] cap_c [0:140];

    logic [1:0]  nsel;
    logic [15:0] nsolid;
    int          drop_k;

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    localparam logic [7:0] BAR_LINE [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                             8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    dvp_pattern_tx_if dvp ();

    dvp_pattern_tx #(
        .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .I_pxl_clk     (clk),
        .I_rst_n       (rst_n),
        .I_en          (en),
        .I_pattern_sel (sel),
        .I_solid_rgb   (solid),
        .o_dvp         (dvp),
        .O_busy        (busy),
        .O_frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Index k holds outputs seen just after the k-th edge following the start edge.
    task automatic run_frame();
        for (int k = 1; k <= 140; k++) begin
            tick();
            cap_v[k] = dvp.O_vsync;
            cap_h[k] = dvp.O_href;
            cap_b[k] = busy;
            cap_d[k] = dvp.O_data;
            cap_c[k] = frame_cnt;
            if (k == 70) begin
                sel   = nsel;
                solid = nsolid;
            end
            if (k == drop_k) en = 1'b0;
        end
    endtask

    function automatic logic [15:0] exp_px(input int s, input int x, input int y, input logic [15:0] sv);
        logic [7:0] x8, y8;
        x8 = 8'(x);
        y8 = 8'(y);
        case (s)
            0:       return BARS[x / (H_ACTIVE / 8)];
            1:       return {x8[7:3], x8[7:2], x8[7:3]};
            2:       return (x8[4] ^ y8[4]) ? 16'hFFFF : 16'h0000;
            default: return sv;
        endcase
    endfunction

    task automatic check_frame(input string tag, input logic [15:0] exp_cnt);
        int   rises, hi, vhi, dbad, bbad;
        logic prev;
        rises = 0; hi = 0; vhi = 0; dbad = 0; bbad = 0; prev = 1'b0;
        for (int k = 1; k <= 140; k++) begin
            if (cap_h[k] && !prev) rises++;
            prev = cap_h[k];
            if (cap_h[k]) hi++;
            if (cap_v[k]) vhi++;
            if (!cap_h[k] && cap_d[k] != 8'h00) dbad++;
            if (!cap_b[k]) bbad++;
        end
        chk({tag, "_vs_first"},  32'(cap_v[1]), 1);
        chk({tag, "_vs_last"},   32'(cap_v[20]), 1);
        chk({tag, "_vs_fall"},   32'(cap_v[21]), 0);
        chk({tag, "_vs_len"},    vhi, 20);
        chk({tag, "_href_pre"},  32'(cap_h[40]), 0);
        chk({tag, "_href_rise"}, 32'(cap_h[41]), 1);
        chk({tag, "_href_fall"}, 32'(cap_h[57]), 0);
        chk({tag, "_href_cnt"},  rises, 4);
        chk({tag, "_href_clks"}, hi, 64);
        chk({tag, "_data_blank"}, dbad, 0);
        chk({tag, "_busy"},      bbad, 0);
        chk({tag, "_cnt_before"}, 32'(cap_c[139]), 32'(16'(exp_cnt - 16'd1)));
        chk({tag, "_cnt_after"},  32'(cap_c[140]), 32'(exp_cnt));
    endtask

    task automatic check_pattern(input string tag, input int s, input logic [15:0] sv);
        int         errs;
        int         k;
        logic [15:0] px;
        logic [7:0]  eb;
        errs = 0;
        for (int ln = 0; ln < 4; ln++) begin
            for (int b = 0; b < 16; b++) begin
                k  = 41 + 20 * ln + b;
                px = exp_px(s, b / 2, ln, sv);
                eb = (b % 2 == 1) ? px[7:0] : px[15:8];
                if (!cap_h[k] || cap_d[k] !== eb) errs++;
            end
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        #1;
        chk("rst_vsync", 32'(dvp.O_vsync), 0);
        chk("rst_href",  32'(dvp.O_href), 0);
        chk("rst_data",  32'(dvp.O_data), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_cnt",   32'(frame_cnt), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (50) tick();
        chk("idle_vsync", 32'(dvp.O_vsync), 0);
        chk("idle_href",  32'(dvp.O_href), 0);
        chk("idle_busy",  32'(busy), 0);
        chk("idle_cnt",   32'(frame_cnt), 0);

        // Frame A: colour bars; sel switched to solid mid-frame must not leak in.
        sel = 2'd0; en = 1'b1;
        tick();
        chk("A_vs_edgeN", 32'(dvp.O_vsync), 0);
        nsel = 2'd3; nsolid = 16'hABCD; drop_k = 0;
        run_frame();
        check_frame("A", 16'd1);
        check_pattern("A_pix", 0, 16'h0000);
        for (int b = 0; b < 16; b++) chk($sformatf("A_bar_byte%0d", b), 32'(cap_d[41 + b]), 32'(BAR_LINE[b]));
        chk("A_vfront_gap", 32'(cap_v[140]), 0);

        // Frame B: back-to-back solid colour; sel changed to checkerboard mid-frame.
        nsel = 2'd2; nsolid = 16'hABCD;
        run_frame();
        check_frame("B", 16'd2);
        check_pattern("B_pix", 3, 16'hABCD);

        // Frame C: checkerboard; en dropped at start of active line 2.
        drop_k = 80;
        run_frame();
        check_frame("C", 16'd3);
        check_pattern("C_pix", 2, 16'h0000);
        tick();
        chk("C_idle_busy",  32'(busy), 0);
        chk("C_idle_vsync", 32'(dvp.O_vsync), 0);
        repeat (10) tick();
        chk("C_idle_stay", 32'(busy), 0);

        // Frame D: grey ramp, single frame.
        sel = 2'd1; en = 1'b1; nsel = 2'd1; drop_k = 70;
        tick();
        run_frame();
        check_frame("D", 16'd4);
        check_pattern("D_pix", 1, 16'h0000);
        tick();
        chk("D_idle_busy", 32'(busy), 0);

        // Reset during an href byte, then a full restart.
        sel = 2'd0; en = 1'b1;
        tick();
        repeat (45) tick();
        chk("F_pre_href", 32'(dvp.O_href), 1);
        chk("F_pre_cnt",  32'(frame_cnt), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("F_rst_href",  32'(dvp.O_href), 0);
        chk("F_rst_vsync", 32'(dvp.O_vsync), 0);
        chk("F_rst_data",  32'(dvp.O_data), 0);
        chk("F_rst_cnt",   32'(frame_cnt), 0);
        chk("F_rst_busy",  32'(busy), 0);
        tick();
        rst_n = 1'b1;
        nsel = 2'd0; drop_k = 70;
        tick();
        run_frame();
        check_frame("G", 16'd1);
        check_pattern("G_pix", 0, 16'h0000);

        // Frame counter wrap.
        tick();
        force dut.r_frame_cnt = 16'hFFFF;
        tick();
        release dut.r_frame_cnt;
        tick();
        chk("E_cnt_forced", 32'(frame_cnt), 32'h0000FFFF);
        sel = 2'd3; solid = 16'h1234; nsel = 2'd3; nsolid = 16'h1234; en = 1'b1; drop_k = 70;
        tick();
        run_frame();
        check_frame("E", 16'h0000);
        check_pattern("E_pix", 3, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
